// File: rtl/xor_64_bit_if.sv
// Operand/result bundle for xor_64_bit: operands in, combinational and registered results out.
// The master drives operands; the slave returns Y, the registered result and its flags.
interface xor_64_bit_if #(
   parameter int WIDTH = 64
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             in_valid;
   logic [WIDTH-1:0] Y;
   logic [WIDTH-1:0] Y_q;
   logic             out_valid;
   logic             zf;
   logic             sf;
   logic             pf;
   logic [CW-1:0]    popcnt;

   modport master (
      output A, B, in_valid,
      input  Y, Y_q, out_valid, zf, sf, pf, popcnt
   );

   modport slave (
      input  A, B, in_valid,
      output Y, Y_q, out_valid, zf, sf, pf, popcnt
   );
endinterface

// File: rtl/xor_64_bit.sv
// Purpose: bitwise XOR with combinational Y plus registered result, zero/sign/parity flags and popcount.
// Latency: Y is 0 cycles; Y_q, flags and out_valid update 1 cycle after an in_valid edge.
// Backpressure: none; every cycle with in_valid=1 is accepted, back-to-back supported.
module xor_64_bit #(
   parameter int WIDTH = 64
) (
   input logic         clk,
   input logic         rst,
   xor_64_bit_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] y_d;
   logic [CW-1:0]    cnt_d;

   logic [WIDTH-1:0] y_q;
   logic [CW-1:0]    cnt_q;
   logic             vld_q;
   logic             zf_q;
   logic             sf_q;
   logic             pf_q;

   always_comb begin
      y_d = bus.A ^ bus.B;
   end

   // Counter is CW bits wide so the all-ones result reads as WIDTH without wrapping.
   always_comb begin
      cnt_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d = cnt_d + CW'(y_d[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= 1'b0;
         y_q   <= '0;
         cnt_q <= '0;
         zf_q  <= 1'b1;
         sf_q  <= 1'b0;
         pf_q  <= 1'b0;
      end else begin
         vld_q <= bus.in_valid;
         if (bus.in_valid) begin
            y_q   <= y_d;
            cnt_q <= cnt_d;
            zf_q  <= (cnt_d == '0);
            sf_q  <= y_d[WIDTH-1];
            pf_q  <= cnt_d[0];
         end
      end
   end

   assign bus.Y         = y_d;
   assign bus.Y_q       = y_q;
   assign bus.out_valid = vld_q;
   assign bus.zf        = zf_q;
   assign bus.sf        = sf_q;
   assign bus.pf        = pf_q;
   assign bus.popcnt    = cnt_q;
endmodule

// File: tb/tb_xor_64_bit.sv
// Scoreboard bench for xor_64_bit: expected results queued at drive time, popped when out_valid rises.
module tb_xor_64_bit;
   typedef struct packed {
      logic [63:0] y;
      logic [6:0]  cnt;
      logic        zf;
      logic        sf;
      logic        pf;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   exp_t sb[$];

   xor_64_bit_if #(.WIDTH(64)) bus ();

   xor_64_bit #(.WIDTH(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b);
      exp_t        e;
      logic [63:0] r;
      r     = a ^ b;
      e.y   = r;
      e.cnt = 7'($countones(r));
      e.zf  = (r == 64'd0);
      e.sf  = r[63];
      e.pf  = ^r;
      return e;
   endfunction

   task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic v);
      @(negedge clk);
      bus.A        = a;
      bus.B        = b;
      bus.in_valid = v;
      if (v) sb.push_back(model(a, b));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t obs;
      rst          = 1'b1;
      bus.A        = 64'hDEAD_BEEF_0000_FFFF;
      bus.B        = 64'h0123_4567_89AB_CDEF;
      bus.in_valid = 1'b1;
      #1;
      obs = {bus.Y_q, bus.popcnt, bus.zf, bus.sf, bus.pf};
      checks++;
      if (obs !== {64'd0, 7'd0, 1'b1, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_state got=%h want=%h", obs, {64'd0, 7'd0, 1'b1, 1'b0, 1'b0});
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
      end
      checks++;
      if (bus.Y !== (64'hDEAD_BEEF_0000_FFFF ^ 64'h0123_4567_89AB_CDEF)) begin
         failures++;
         $display("FAIL reset_y_comb got=%h want=%h", bus.Y, 64'hDEAD_BEEF_0000_FFFF ^ 64'h0123_4567_89AB_CDEF);
      end
      // in_valid held high across an edge while in reset must be discarded
      step();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.Y_q !== 64'd0 || bus.zf !== 1'b1) begin
         failures++;
         $display("FAIL reset_discard got vld=%b yq=%h zf=%b want vld=0 yq=0 zf=1", bus.out_valid, bus.Y_q, bus.zf);
      end
      @(negedge clk);
      rst          = 1'b0;
      bus.in_valid = 1'b0;
   endtask

   task automatic test_patterns();
      logic [63:0] av[5];
      logic [63:0] bv[5];
      logic [6:0]  cv[5];
      exp_t        e;
      exp_t        obs;
      av = '{64'hCCCC_CCCC_CCCC_CCCC, 64'hF0F0_F0F0_F0F0_F0F0, 64'h1234_5678_9ABC_DEF0,
             64'h8000_0000_0000_0000, 64'h0000_0000_0000_0007};
      bv = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h0F0F_0F0F_0F0F_0F0F, 64'h1234_5678_9ABC_DEF0,
             64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};
      cv = '{7'd32, 7'd64, 7'd0, 7'd1, 7'd3};
      for (int i = 0; i < 5; i++) begin
         drive(av[i], bv[i], 1'b1);
         #1;
         checks++;
         if (bus.Y !== (av[i] ^ bv[i])) begin
            failures++;
            $display("FAIL pattern_y[%0d] got=%h want=%h", i, bus.Y, av[i] ^ bv[i]);
         end
         step();
         checks++;
         if (bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL pattern_vld[%0d] got=%b want=1", i, bus.out_valid);
         end
         e   = sb.pop_front();
         obs = {bus.Y_q, bus.popcnt, bus.zf, bus.sf, bus.pf};
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL pattern_out[%0d] got=%h want=%h", i, obs, e);
         end
         checks++;
         if (bus.popcnt !== cv[i]) begin
            failures++;
            $display("FAIL pattern_popcnt[%0d] got=%0d want=%0d", i, bus.popcnt, cv[i]);
         end
      end
      drive(64'd0, 64'd0, 1'b0);
      step();
   endtask

   task automatic test_hold();
      exp_t e;
      exp_t obs;
      drive(64'h1, 64'h0, 1'b1);
      step();
      e   = sb.pop_front();
      obs = {bus.Y_q, bus.popcnt, bus.zf, bus.sf, bus.pf};
      checks++;
      if (obs !== e || bus.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL hold_capture got=%h vld=%b want=%h vld=1", obs, bus.out_valid, e);
      end
      for (int i = 0; i < 3; i++) begin
         drive(64'hFF << i, 64'h0, 1'b0);
         #1;
         checks++;
         if (bus.Y !== (64'hFF << i)) begin
            failures++;
            $display("FAIL hold_y_tracks[%0d] got=%h want=%h", i, bus.Y, 64'hFF << i);
         end
         step();
         obs = {bus.Y_q, bus.popcnt, bus.zf, bus.sf, bus.pf};
         checks++;
         if (obs !== {64'h1, 7'd1, 1'b0, 1'b0, 1'b1} || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_value[%0d] got=%h vld=%b want=%h vld=0", i, obs, bus.out_valid,
                     {64'h1, 7'd1, 1'b0, 1'b0, 1'b1});
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      exp_t obs;
      for (int i = 0; i < 24; i++) begin
         drive({$urandom, $urandom}, (i % 6 == 5) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom}, 1'b1);
         step();
         checks++;
         if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL b2b_vld[%0d] got=%b want=1 pending=%0d", i, bus.out_valid, sb.size());
         end else begin
            e   = sb.pop_front();
            obs = {bus.Y_q, bus.popcnt, bus.zf, bus.sf, bus.pf};
            checks++;
            if (obs !== e) begin
               failures++;
               $display("FAIL b2b_out[%0d] got=%h want=%h", i, obs, e);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      exp_t        e;
      exp_t        obs;
      logic [63:0] a;
      logic [63:0] b;
      drive(64'h0F00_0000_0000_00F0, 64'h0000_0000_0000_0001, 1'b1);
      step();
      e = sb.pop_front();
      checks++;
      if (bus.Y_q !== e.y) begin
         failures++;
         $display("FAIL arst_pre got=%h want=%h", bus.Y_q, e.y);
      end
      // keep in_valid high so the following rising edge would capture if reset were ignored
      a = 64'h5555_0000_AAAA_1111;
      b = 64'h0000_FFFF_0000_1111;
      drive(a, b, 1'b1);
      sb.delete();
      #2;
      rst = 1'b1;
      #1;
      obs = {bus.Y_q, bus.popcnt, bus.zf, bus.sf, bus.pf};
      checks++;
      if (obs !== {64'd0, 7'd0, 1'b1, 1'b0, 1'b0} || bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL arst_immediate got=%h vld=%b want=%h vld=0", obs, bus.out_valid,
                  {64'd0, 7'd0, 1'b1, 1'b0, 1'b0});
      end
      checks++;
      if (bus.Y !== (a ^ b)) begin
         failures++;
         $display("FAIL arst_y_comb got=%h want=%h", bus.Y, a ^ b);
      end
      @(negedge clk);
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(a + 64'(i), b, 1'b1);
         step();
         e   = sb.pop_front();
         obs = {bus.Y_q, bus.popcnt, bus.zf, bus.sf, bus.pf};
         checks++;
         if (obs !== e || bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL arst_resume[%0d] got=%h vld=%b want=%h vld=1", i, obs, bus.out_valid, e);
         end
      end
      drive(64'd0, 64'd0, 1'b0);
      step();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL arst_drain got=%b want=0", bus.out_valid);
      end
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      rst          = 1'b1;
      bus.A        = 64'd0;
      bus.B        = 64'd0;
      bus.in_valid = 1'b0;
      test_reset();
      test_patterns();
      test_hold();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule
